// File: rtl/mem8_share_arbiter.sv
// Two-port round-robin arbiter sharing one register/RAM space:
// address 0 = LED register, address 1 = synchronized buttons, 2.. = RAM.
module mem8_share_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LED_W  = 4,
  parameter int unsigned BTN_W  = 4
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic [BTN_W-1:0]  btn_in,
  output logic [LED_W-1:0]  led_out,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;      // 0 = A, 1 = B
  logic                rr_ptr;     // 0 = A preferred, 1 = B preferred
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [LED_W-1:0]    led_reg;
  logic [BTN_W-1:0]    btn_meta;
  logic [BTN_W-1:0]    btn_sync;
  logic [DATA_W-1:0]   rdata_reg;
  logic [DATA_W-1:0]   mem [2:DEPTH-1];
  logic                a_elig;
  logic                b_elig;
  logic                grant;
  logic                grant_b;
  logic                addr_is_led;
  logic                addr_is_btn;

  assign addr_is_led = (lat_addr == '0);
  assign addr_is_btn = (lat_addr == ADDR_W'(1));
  assign busy        = (state != ST_IDLE);
  assign led_out     = led_reg;

  // Next-state and arbitration decision.
  // A requester whose ack is currently high is masked: it is dropping req
  // (or changing fields) on this edge, so its level must not re-grant.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_b   = 1'b0;
    a_elig    = a_req & ~a_ack;
    b_elig    = b_req & ~b_ack;
    case (state)
      ST_IDLE: begin
        if (a_elig || b_elig) begin
          grant     = 1'b1;
          grant_b   = b_elig & (~a_elig | rr_ptr);
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Capture the winning requester's transaction fields.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      owner     <= grant_b;
      lat_we    <= grant_b ? b_we    : a_we;
      lat_addr  <= grant_b ? b_addr  : a_addr;
      lat_wdata <= grant_b ? b_wdata : a_wdata;
    end
  end

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
    end
  end

  // Register-side access during XFER: LED writes and read-data capture.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      led_reg   <= '0;
      rdata_reg <= '0;
    end else if (state == ST_XFER) begin
      if (lat_we) begin
        if (addr_is_led) led_reg <= lat_wdata[LED_W-1:0];
      end else if (addr_is_led) begin
        rdata_reg <= DATA_W'(led_reg);
      end else if (addr_is_btn) begin
        rdata_reg <= DATA_W'(btn_sync);
      end else begin
        rdata_reg <= mem[lat_addr];
      end
    end
  end

  // General-purpose RAM writes (contents intentionally not reset).
  always_ff @(posedge bus_clk) begin
    if (state == ST_XFER && lat_we && !addr_is_led && !addr_is_btn)
      mem[lat_addr] <= lat_wdata;
  end

  // Response: one-cycle ack and read data to the owner, then flip the pointer.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      rr_ptr  <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (state == ST_RESP) begin
        rr_ptr <= ~owner;
        if (owner) begin
          b_ack   <= 1'b1;
          b_rdata <= rdata_reg;
        end else begin
          a_ack   <= 1'b1;
          a_rdata <= rdata_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem8_share_arbiter.sv
// Self-checking bench for mem8_share_arbiter: directed steps plus random
// rounds, checked against a transaction-level model of the shared space.
module tb_mem8_share_arbiter;

  logic       bus_clk = 1'b0;
  logic       bus_rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic       a_ack, b_ack;
  logic [3:0] btn_in, led_out;
  logic       busy;

  always #5 bus_clk = ~bus_clk;

  mem8_share_arbiter #(
    .ADDR_W(5),
    .DATA_W(8),
    .LED_W (4),
    .BTN_W (4)
  ) dut (
    .bus_clk  (bus_clk),
    .bus_rst_n(bus_rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .btn_in   (btn_in),
    .led_out  (led_out),
    .busy     (busy)
  );

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;
  } op_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model of the shared space and arbitration pointer.
  logic [7:0] m_ram [32];
  bit         m_ok  [32];
  logic [3:0] m_led;
  logic [3:0] m_btn;
  bit         m_ptr;   // 0: A preferred on contention, 1: B preferred
  op_t        qa[$];
  op_t        qb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic op_t mk(input logic we, input logic [4:0] addr, input logic [7:0] wd);
    op_t o;
    o.we = we; o.addr = addr; o.wd = wd;
    return o;
  endfunction

  function automatic logic [7:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return {4'b0, m_led};
    if (addr == 5'd1) return {4'b0, m_btn};
    return m_ram[addr];
  endfunction

  task automatic model_reset();
    m_led = 4'h0;
    m_ptr = 1'b0;
    for (int i = 0; i < 32; i++) m_ok[i] = 1'b0;
  endtask

  task automatic drive_a();
    if (qa.size() != 0) begin
      a_req = 1'b1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wd;
    end else a_req = 1'b0;
  endtask

  task automatic drive_b();
    if (qb.size() != 0) begin
      b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wd;
    end else b_req = 1'b0;
  endtask

  task automatic finish_op(input bit side, input op_t op, input int lat,
                           input bit chk_lat, input logic [7:0] rd);
    string nm;
    nm = side ? "B" : "A";
    if (chk_lat) check({nm, "_latency"}, lat, 3);
    if (!op.we) begin
      if (op.addr < 5'd2 || m_ok[op.addr])
        check({nm, "_rdata"}, rd, model_read(op.addr));
    end else begin
      if (op.addr == 5'd0) m_led = op.wd[3:0];
      else if (op.addr >= 5'd2) begin
        m_ram[op.addr] = op.wd;
        m_ok[op.addr]  = 1'b1;
      end
    end
    check("led_out", led_out, m_led);
    m_ptr = ~side;
  endtask

  // Run both queues to completion; each requester holds req until acked.
  task automatic serve(input bit chk_lat);
    int  lat_a, lat_b, budget;
    bit  upd_a, upd_b, prev_a, prev_b, pred;
    op_t op;
    budget = 20 * (qa.size() + qb.size()) + 10;
    lat_a = 0; lat_b = 0; upd_a = 0; upd_b = 0; prev_a = 0; prev_b = 0;
    @(posedge bus_clk); #1;
    drive_a(); drive_b();
    while ((qa.size() != 0 || qb.size() != 0) && budget > 0) begin
      @(posedge bus_clk); #1;
      if (upd_a) begin drive_a(); lat_a = 0; upd_a = 0; end else lat_a++;
      if (upd_b) begin drive_b(); lat_b = 0; upd_b = 0; end else lat_b++;
      @(negedge bus_clk);
      budget--;
      if (prev_a) check("a_ack_width", a_ack, 0);
      if (prev_b) check("b_ack_width", b_ack, 0);
      prev_a = a_ack; prev_b = b_ack;
      if (a_ack || b_ack) begin
        check("ack_exclusive", a_ack & b_ack, 0);
        pred = (qa.size() != 0 && qb.size() != 0) ? m_ptr : (qa.size() == 0);
        check("grant_owner_is_b", b_ack, pred);
        if (a_ack) begin
          if (qa.size() == 0) check("a_ack_unexpected", 1, 0);
          else begin
            op = qa.pop_front();
            finish_op(1'b0, op, lat_a, chk_lat, a_rdata);
            upd_a = 1;
          end
        end
        if (b_ack) begin
          if (qb.size() == 0) check("b_ack_unexpected", 1, 0);
          else begin
            op = qb.pop_front();
            finish_op(1'b1, op, lat_b, chk_lat, b_rdata);
            upd_b = 1;
          end
        end
      end
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      check("serve_timeout_pending", qa.size() + qb.size(), 0);
      qa.delete(); qb.delete();
    end
    @(posedge bus_clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge bus_clk);
    check("ack_after_done", {a_ack, b_ack}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    bus_rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    btn_in = 4'h0;
    m_btn  = 4'h0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge bus_clk);
    #1;
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_led", led_out, 0);
    check("rst_busy", busy, 0);
    @(posedge bus_clk); #1;
    bus_rst_n = 1'b1;

    // A writes LED register.
    qa.push_back(mk(1, 5'd0, 8'h0A));
    serve(1);
    check("led_after_a_write", led_out, 4'hA);

    // Buttons through the synchronizer, read by B.
    btn_in = 4'b0110;
    repeat (3) @(posedge bus_clk);
    m_btn = 4'b0110;
    qb.push_back(mk(0, 5'd1, 8'h00));
    serve(1);

    // RAM write by A, read by B; write to button address is ignored.
    qa.push_back(mk(1, 5'd5, 8'h3C));
    serve(1);
    qb.push_back(mk(0, 5'd5, 8'h00));
    serve(1);
    qa.push_back(mk(1, 5'd1, 8'hFF));
    serve(1);
    qb.push_back(mk(0, 5'd1, 8'h00));
    serve(1);

    // Continuous contention: must alternate A, B, A, B, A, B.
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mk(1, 5'd7, 8'h11));
      qb.push_back(mk(0, 5'd7, 8'h00));
    end
    serve(0);

    // B alone, back-to-back reads.
    qa.push_back(mk(1, 5'd2, 8'hA2));
    qa.push_back(mk(1, 5'd3, 8'hB3));
    qa.push_back(mk(1, 5'd4, 8'hC4));
    serve(1);
    qb.push_back(mk(0, 5'd2, 8'h00));
    qb.push_back(mk(0, 5'd3, 8'h00));
    qb.push_back(mk(0, 5'd4, 8'h00));
    serve(1);

    // Reset asserted during XFER of an A write to the LED register.
    @(posedge bus_clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = 8'h0F;
    @(posedge bus_clk); #1;
    check("busy_in_xfer", busy, 1);
    bus_rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_led", led_out, 0);
    check("abort_a_ack", a_ack, 0);
    a_req = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge bus_clk);
      check("abort_no_ack", a_ack, 0);
    end
    @(posedge bus_clk); #1;
    bus_rst_n = 1'b1;
    repeat (3) @(posedge bus_clk);
    qa.push_back(mk(1, 5'd0, 8'h05));
    qa.push_back(mk(0, 5'd0, 8'h00));
    serve(1);
    qb.push_back(mk(0, 5'd1, 8'h00));
    serve(1);

    // Random rounds against the model.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        btn_in = 4'($urandom);
        repeat (3) @(posedge bus_clk);
        m_btn = btn_in;
      end
      na = $urandom_range(0, 4);
      nb = $urandom_range(0, 4);
      if (na == 0 && nb == 0) na = 1;
      for (int i = 0; i < na; i++)
        qa.push_back(mk(1'($urandom), 5'($urandom_range(0, 9)), 8'($urandom)));
      for (int i = 0; i < nb; i++)
        qb.push_back(mk(1'($urandom), 5'($urandom_range(0, 9)), 8'($urandom)));
      serve(na == 0 || nb == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
